// File: rtl/round_robin_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : round_robin_fifo_arbiter
// Description : Four write-side FIFOs drained one entry per turn by a fixed
//               A->B->C->D rotation. Optional macro RR_ARB_DOUT_HOLD_EN keeps
//               dout at its last read value while valid is low.
// Revision    : 1.0 - initial release
// ============================================================================
module round_robin_fifo_arbiter #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        wen,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] dout,
    output logic              valid
);

    localparam int             PTR_W        = $clog2(DEPTH);
    localparam logic [PTR_W:0] c_full_count = (PTR_W + 1)'(DEPTH);

    logic [3:0][DATA_W-1:0] w_din;
    logic [3:0][DATA_W-1:0] w_head;
    logic [3:0]             w_empty;
    logic [3:0]             w_pop;
    logic [3:0]             w_sel_onehot;
    logic [1:0]             r_sel;

    assign w_din        = {d, c, b, a};
    assign w_sel_onehot = 4'b0001 << r_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fifo
            logic [DATA_W-1:0] r_mem [DEPTH];
            logic [PTR_W-1:0]  r_wptr;
            logic [PTR_W-1:0]  r_rptr;
            logic [PTR_W:0]    r_count;
            logic              w_push;

            // A pop needs wen low on the same FIFO, so push and pop never coincide here.
            assign w_empty[gi] = (r_count == '0);
            assign w_push      = wen[gi] && (r_count != c_full_count);
            assign w_pop[gi]   = w_sel_onehot[gi] && !wen[gi] && !w_empty[gi];
            assign w_head[gi]  = r_mem[r_rptr];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                end else begin
                    if (w_push) begin
                        r_wptr  <= r_wptr + 1'b1;
                        r_count <= r_count + 1'b1;
                    end
                    if (w_pop[gi]) begin
                        r_rptr  <= r_rptr + 1'b1;
                        r_count <= r_count - 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst_n && w_push) begin
                    r_mem[r_wptr] <= w_din[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel <= 2'd0;
            dout  <= '0;
            valid <= 1'b0;
        end else begin
            r_sel <= r_sel + 2'd1;
            valid <= |w_pop;
`ifdef RR_ARB_DOUT_HOLD_EN
            if (|w_pop) begin
                dout <= w_head[r_sel];
            end
`else
            dout <= (|w_pop) ? w_head[r_sel] : '0;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_round_robin_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_round_robin_fifo_arbiter
// Description : Scoreboard bench for round_robin_fifo_arbiter with a
//               cycle-level reference model of the four FIFOs and the rotation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_round_robin_fifo_arbiter;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;

    logic              clk;
    logic              rst_n;
    logic [3:0]        wen;
    logic [DATA_W-1:0] a, b, c, d;
    logic [DATA_W-1:0] dout;
    logic              valid;

    round_robin_fifo_arbiter #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wen   (wen),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .dout  (dout),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] dout;
    } exp_t;

    exp_t              exp_q [$];
    logic [DATA_W-1:0] mq [4][$];
    logic [1:0]        m_sel;
    logic [DATA_W-1:0] m_dout;
    int                n_checks;
    int                n_fail;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mq[i].delete();
        m_sel  = 2'd0;
        m_dout = '0;
    endtask

    // One non-reset edge: drive inputs, predict, then compare after the edge.
    task automatic step(input logic [3:0] w, input logic [DATA_W-1:0] va, input logic [DATA_W-1:0] vb,
                        input logic [DATA_W-1:0] vc, input logic [DATA_W-1:0] vd, input string tag);
        logic [DATA_W-1:0] din [4];
        exp_t              e;
        exp_t              got;
        @(negedge clk);
        rst_n = 1'b1;
        wen   = w;
        a = va; b = vb; c = vc; d = vd;
        din[0] = va; din[1] = vb; din[2] = vc; din[3] = vd;
        e.valid = 1'b0;
        if (!w[m_sel] && mq[m_sel].size() > 0) begin
            m_dout  = mq[m_sel].pop_front();
            e.valid = 1'b1;
        end else begin
`ifndef RR_ARB_DOUT_HOLD_EN
            m_dout = '0;
`endif
        end
        e.dout = m_dout;
        for (int i = 0; i < 4; i++) begin
            if (w[i] && mq[i].size() < DEPTH) mq[i].push_back(din[i]);
        end
        m_sel = m_sel + 2'd1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_value({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e   = exp_q.pop_front();
            got = '{valid: valid, dout: dout};
            check_value({tag, "_valid"}, 32'(got.valid), 32'(e.valid));
            check_value({tag, "_dout"},  32'(got.dout),  32'(e.dout));
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) step(4'b0000, '0, '0, '0, '0, tag);
    endtask

    task automatic do_reset(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            rst_n = 1'b0;
            wen   = 4'($urandom);
            a = DATA_W'($urandom); b = DATA_W'($urandom);
            c = DATA_W'($urandom); d = DATA_W'($urandom);
            @(posedge clk);
            #1;
            check_value("rst_valid", 32'(valid), 32'd0);
            check_value("rst_dout",  32'(dout),  32'd0);
        end
        model_reset();
        exp_q.delete();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        wen      = '0;
        a = '0; b = '0; c = '0; d = '0;
        model_reset();
        do_reset(2);

        // Single writes on separate cycles, then drain in A-B-C-D order.
        step(4'b0001, 8'd10, 8'd0,  8'd0,  8'd0,  "wr_a");
        step(4'b0010, 8'd0,  8'd20, 8'd0,  8'd0,  "wr_b");
        step(4'b0100, 8'd0,  8'd0,  8'd30, 8'd0,  "wr_c");
        step(4'b1000, 8'd0,  8'd0,  8'd0,  8'd40, "wr_d");
        idle(8, "drain_abcd");

        // Simultaneous writes to C and D.
        step(4'b1100, 8'd0, 8'd0, 8'd50, 8'd60, "wr_cd");
        idle(4, "drain_cd");

        // Reach sel=A, then full-width write that conflicts on A.
        idle(3, "align_a");
        step(4'b1111, 8'd87, 8'd56, 8'd9, 8'd13, "conflict_a");
        idle(4, "drain_all4");

        // Write to A on its own turn while it already holds data.
        step(4'b0001, 8'd5, 8'd0, 8'd0, 8'd0, "prefill_a");
        idle(2, "align_a2");
        step(4'b0001, 8'd6, 8'd0, 8'd0, 8'd0, "conflict_a_held");
        idle(8, "drain_a_held");

        // Overflow: DEPTH+1 back-to-back writes to A.
        for (int k = 0; k <= DEPTH; k++) begin
            step(4'b0001, DATA_W'(100 + k), 8'd0, 8'd0, 8'd0, "fill_a");
        end
        idle(4 * (DEPTH + 1), "drain_overflow");

        // Random traffic.
        for (int k = 0; k < 300; k++) begin
            step(4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                 DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom), "rand");
        end

        // Mid-operation reset with data pending and sel away from A.
        step(4'b1111, 8'd1, 8'd2, 8'd3, 8'd4, "pre_rst_fill");
        step(4'b1111, 8'd5, 8'd6, 8'd7, 8'd8, "pre_rst_fill2");
        do_reset(1);
        idle(4, "post_rst_empty");
        step(4'b0010, 8'd0, 8'd77, 8'd0, 8'd0, "post_rst_wr_b");
        idle(1, "post_rst_rd_b");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/round_robin_fifo_arbiter.md
ROUND_ROBIN_FIFO_ARBITER -- requirements
Module: round_robin_fifo_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-low reset, named clk and rst_n.
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the data width of every input, FIFO entry and dout.
REQ-003 The block SHALL have parameter DEPTH, default 8, giving the entries per FIFO (power of two, >= 2).
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock; all state changes on this edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 The block SHALL have port wen, input, 4 bits: per-FIFO write enable; bit0=A, bit1=B, bit2=C, bit3=D.
REQ-007 The block SHALL have ports a, b, c, d, input, DATA_W bits each: write data for FIFO A, B, C and D.
REQ-008 The block SHALL have port dout, output, DATA_W bits: registered data read from the selected FIFO.
REQ-009 The block SHALL have port valid, output, 1 bit: high for the cycle in which dout holds read data.

Function
REQ-010 The block SHALL contain four independent FIFOs (A-D), each with DEPTH entries and circular read/write pointers that wrap at DEPTH.
REQ-011 On each clk edge with rst_n=1 and wen[i]=1, FIFO i SHALL push its input when not full; a write to a full FIFO SHALL be dropped and leave contents and pointers unchanged.
REQ-012 Writes to several FIFOs in the same cycle SHALL all take effect in that cycle.
REQ-013 A 2-bit selector sel SHALL visit A->B->C->D->A, advancing by one on every non-reset edge whether or not a read occurs.
REQ-014 On each non-reset edge, if FIFO[sel] is non-empty and wen[sel]=0, the block SHALL pop it, set dout to the popped entry and set valid=1.
REQ-015 If FIFO[sel] is empty, or wen[sel]=1 (read/write conflict), the block SHALL perform no pop, clear valid to 0 and clear dout to 0, and that FIFO's turn is lost.
REQ-016 Read latency SHALL be one cycle: dout/valid update on the edge where the selected FIFO is evaluated.
REQ-017 A write to FIFO j where j differs from sel SHALL not block the read of FIFO[sel] in the same cycle.
REQ-018 Data SHALL leave each FIFO in first-in, first-out order.

Reset
REQ-019 With rst_n=0 at a clk edge, the block SHALL empty all four FIFOs, set all pointers to 0, set sel=A, dout=0 and valid=0; wen is ignored during reset.
REQ-020 A reset asserted mid-operation SHALL discard all stored data; the first evaluated FIFO after release SHALL be A.

Configuration
REQ-021 With macro RR_ARB_DOUT_HOLD_EN defined, dout SHALL hold its last read value when valid=0 (cleared to 0 only by reset).
REQ-022 Without RR_ARB_DOUT_HOLD_EN, dout SHALL be 0 whenever valid=0, as in REQ-015.

Verification
REQ-023 The bench SHALL check: after reset, write 10 to A, 20 to B, 30 to C and 40 to D on separate cycles, then wen=0 -> valid pulses deliver 10, 20, 30, 40 in A-B-C-D turn order, with valid=0 on turns that find their FIFO empty.
REQ-024 The bench SHALL check: write 50 to C and 60 to D in the same cycle -> both are stored and read on the later C and D turns.
REQ-025 The bench SHALL check: one cycle with sel=A, wen=1111, a=87, b=56, c=9, d=13 -> that edge gives valid=0 (conflict on A), and the next edge (sel=B, wen=0) gives dout=56, valid=1.
REQ-026 The bench SHALL check: a write to A on A's turn while A holds data -> valid=0 and dout=0 on that edge; the stored data is read on A's next turn.
REQ-027 The bench SHALL check: DEPTH+1 writes to A with no reads -> the last write is dropped and exactly DEPTH values (first DEPTH written) are read back in order.
REQ-028 The bench SHALL check: rst_n pulsed low while FIFOs hold data -> dout=0, valid=0, all FIFOs empty, and the next read turn is A.
